// File: rtl/div_16bit_seq.sv
// Sequential signed divider: radix-2 restoring, one quotient bit per clock.
// Start/busy/done handshake with divide-by-zero and overflow flags.
module div_16bit_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sgn_quo_q, sgn_quo_d;
    logic             sgn_rem_q, sgn_rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Magnitude as unsigned; the most-negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
        abs_val = x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        cond_neg = neg ? (~x + 1'b1) : x;
    endfunction

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        count_d   = count_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;

        // The partial remainder stays below |B| <= 2^(WIDTH-1), so the
        // shifted value and the trial difference fit in WIDTH+1 bits.
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dsr_q};

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (B == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = A;
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d   = CALC;
                        dvd_d     = abs_val(A);
                        dsr_d     = abs_val(B);
                        sgn_quo_d = A[WIDTH-1] ^ B[WIDTH-1];
                        sgn_rem_d = A[WIDTH-1];
                        rem_d     = '0;
                        count_d   = '0;
                    end
                end
            end
            CALC: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            FIX: begin
                state_d = DONE;
                quo_d   = cond_neg(dvd_q, sgn_quo_q);
                rmd_d   = cond_neg(rem_q, sgn_rem_q);
                dz_d    = 1'b0;
                // Negative dividend, negative divisor of magnitude 1 and a
                // quotient of 2^(WIDTH-1) can only be most-negative / -1.
                ovf_d   = sgn_rem_q && !sgn_quo_q && (dsr_q == WIDTH'(1)) &&
                          (dvd_q == {1'b1, {(WIDTH-1){1'b0}}});
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            count_q   <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            count_q   <= count_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign Q    = quo_q;
    assign R    = rmd_q;
    assign dz   = dz_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_div_16bit_seq.sv
// Directed self-checking bench for div_16bit_seq: signs, extremes,
// divide-by-zero, handshake corner cases and mid-operation reset.
module tb_div_16bit_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [15:0] Q;
    logic [15:0] R;
    logic        busy;
    logic        done;
    logic        dz;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    div_16bit_seq #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .Q    (Q),
        .R    (R),
        .busy (busy),
        .done (done),
        .dz   (dz),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents operands and a one-cycle start; returns at the falling edge after edge 0.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat = number of rising edges after edge 0 before done is seen.
    // inj >= 0 pulses start with 9/2 at that point while the division runs.
    task automatic wait_done(input int inj, output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (lat == inj) begin
                A = 16'd9;
                B = 16'd2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            bcnt += int'(busy);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edz, input logic eovf, input int elat, input int ebusy);
        int lat;
        int bcnt;
        launch(a, b);
        wait_done(-1, lat, bcnt);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_busy"}, 32'(bcnt), 32'(ebusy));
        check({tag, "_Q"}, 32'(Q), 32'(eq));
        check({tag, "_R"}, 32'(R), 32'(er));
        check({tag, "_dz"}, 32'(dz), 32'(edz));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int bcnt;
        int seen;

        #2;
        check("rst_Q", 32'(Q), 32'd0);
        check("rst_R", 32'(R), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(dz), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("p_p", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 17, 17);
        run("n_p", 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17, 17);
        run("p_n", 16'd100, 16'hFFF9, 16'hFFF2, 16'd2, 1'b0, 1'b0, 17, 17);
        run("n_n", 16'hFF9C, 16'hFFF9, 16'd14, 16'hFFFE, 1'b0, 1'b0, 17, 17);
        run("small", 16'd7, 16'd100, 16'd0, 16'd7, 1'b0, 1'b0, 17, 17);
        run("ovf", 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 1'b1, 17, 17);
        run("max_1", 16'h7FFF, 16'd1, 16'h7FFF, 16'd0, 1'b0, 1'b0, 17, 17);
        run("min_2", 16'h8000, 16'd2, 16'hC000, 16'd0, 1'b0, 1'b0, 17, 17);
        run("min_max", 16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 17, 17);
        run("dz", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1'b0, 0, 0);
        run("after_dz", 16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 1'b0, 17, 17);

        // Start while busy must be ignored.
        launch(16'd50, 16'd5);
        wait_done(5, lat, bcnt);
        check("ign_done", 32'(done), 32'd1);
        check("ign_lat", 32'(lat), 32'd17);
        check("ign_Q", 32'(Q), 32'd10);
        check("ign_R", 32'(R), 32'd0);
        @(negedge clk);
        check("ign_pulse", 32'(done), 32'd0);

        // Start held during the DONE cycle is accepted back-to-back.
        launch(16'd100, 16'd7);
        wait_done(-1, lat, bcnt);
        check("b2b_first_done", 32'(done), 32'd1);
        check("b2b_first_Q", 32'(Q), 32'd14);
        A = 16'd9;
        B = 16'd2;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy0", 32'(busy), 32'd1);
        wait_done(-1, lat, bcnt);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_lat", 32'(lat), 32'd17);
        check("b2b_busy", 32'(bcnt), 32'd17);
        check("b2b_Q", 32'(Q), 32'd4);
        check("b2b_R", 32'(R), 32'd1);
        @(negedge clk);

        // Reset asserted during iteration 8 aborts the division.
        launch(16'd1000, 16'd3);
        repeat (8) @(negedge clk);
        check("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_Q", 32'(Q), 32'd0);
        check("mid_R", 32'(R), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_dz", 32'(dz), 32'd0);
        check("mid_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("mid_no_done", 32'(seen), 32'd0);
        run("post_rst", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0, 17, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_16bit_seq.md
Name: div_16bit_seq

Overview:
- Sequential signed 16-bit divider; inverse of the 16-bit multiplier datapath.
- Computes quotient and remainder with a radix-2 restoring algorithm, one quotient bit per clock.
- Used for FIR gain normalisation and coefficient scaling.
- Start/busy/done handshake; one division in flight at a time.

Parameters:
- WIDTH, 16, operand and result width. All ports scale with it; the tests use 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled on the rising edge.
- A  input  WIDTH  signed dividend, two's complement.
- B  input  WIDTH  signed divisor, two's complement.
- Q  output  WIDTH  signed quotient.
- R  output  WIDTH  signed remainder.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; Q, R, dz and ovf are valid.
- dz  output  1  divide-by-zero flag for the current result.
- ovf  output  1  overflow flag (most-negative divided by -1).

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; Q=0, R=0, busy=0, done=0, dz=0, ovf=0; internal registers cleared.
- Reset mid-operation: the division is aborted, no done pulse follows, and the next start behaves normally.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, B!=0 (call this edge 0):
  - Latch |A| and |B| as WIDTH-bit unsigned (|-32768| = 32768 fits unsigned).
  - Latch sign_q = A[MSB]^B[MSB] and sign_r = A[MSB].
  - Clear the partial remainder; count=0; go to CALC; busy=1.
- IDLE, start=1, B==0:
  - Go to DONE directly; Q=all ones, R=A, dz=1, ovf=0.
  - done is high in the cycle after edge 0; busy stays 0.
- CALC, one iteration per edge:
  - Shift {rem, dividend} left 1.
  - Trial subtract: rem - |B| on WIDTH+1 bits.
  - Non-negative: keep the difference and set quotient bit 1. Otherwise restore and set 0.
  - After 16 iterations (edge 16), go to FIX.
- FIX (edge 17):
  - Q = sign_q ? -q : q. R = sign_r ? -r : r (WIDTH bits, wrap).
  - ovf = (A == -2^(WIDTH-1)) && (B == -1); dz=0.
  - Go to DONE; busy falls.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 here is accepted like IDLE (back-to-back). Otherwise return to IDLE.
- Latency: done is high in the cycle after edge 17, i.e. 17 cycles after the edge that samples start. busy is high for exactly 17 cycles.
- start while busy=1 is ignored; operands are not re-sampled.
- A and B may change freely after edge 0.
- Q, R, dz and ovf hold their value until the next result is written, at FIX or at the dz load.
- Arithmetic: truncation toward zero. R takes the sign of A. |R| < |B|. A = Q*B + R, except in the ovf case.
- Overflow case -32768 / -1: Q = 0x8000 (wrap), R = 0, ovf=1.

Test Plan:
- A=100, B=7, start pulse at edge 0 -> busy high 17 cycles; done after edge 17; Q=14, R=2, dz=0, ovf=0.
- Sign combinations, each run separately:
  - -100/7 -> Q=-14, R=-2.
  - 100/-7 -> Q=-14, R=2.
  - -100/-7 -> Q=14, R=-2.
  - 7/100 -> Q=0, R=7.
- Extremes:
  - -32768/-1 -> Q=0x8000, R=0, ovf=1.
  - 32767/1 -> Q=32767, R=0.
  - -32768/2 -> Q=-16384, R=0.
  - -32768/32767 -> Q=-1, R=-1.
- 1234/0 -> done one cycle after start; dz=1, Q=0xFFFF, R=1234, busy never high. A following 10/3 gives Q=3, R=1, dz=0.
- Handshake:
  - start with 50/5, then start with 9/2 at iteration 5 -> second start is ignored; result Q=10, R=0.
  - start with 9/2 held during the DONE cycle -> accepted back-to-back; Q=4, R=1 after 17 more cycles.
- Reset: rst_n low during iteration 8 of 1000/3 -> all outputs 0 immediately; no done pulse. After release, 1000/3 gives Q=333, R=1.
